bbox_scan_ctrl: RTL and testbench

BBOX_SCAN_CTRL -- requirements
Module: bbox_scan_ctrl

---
 rtl/bbox_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_bbox_scan_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bbox_scan_ctrl.sv
// bbox_scan_ctrl: streams a frame buffer byte-by-byte into a bounding-box detector and latches its result.
// Optional read-timeout watchdog is compiled in with `define BBOX_SCAN_TIMEOUT_EN.
module bbox_scan_ctrl #(
    parameter int WIDTH   = 160,
    parameter int HEIGHT  = 90,
    parameter int TIMEOUT = 255
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rvalid,
    output logic        det_wr_en,
    output logic [31:0] det_data,
    input  logic [31:0] det_out,
    output logic [31:0] bbox_result,
    output logic        bbox_valid
);
    localparam logic [15:0] LAST = 16'(WIDTH * HEIGHT * 3 - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, WAIT, PUSH, DRAIN, DONE, ERROR} state_t;

    state_t      state_q;
    logic        busy_q, done_q, mem_rd_q, det_wr_en_q, bbox_valid_q;
    logic [15:0] mem_addr_q, cnt_q;
    logic [31:0] det_data_q, bbox_result_q;
`ifdef BBOX_SCAN_TIMEOUT_EN
    logic        err_q;
    logic [7:0]  wdg_q;
`endif

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= 16'd0;
            det_wr_en_q   <= 1'b0;
            det_data_q    <= 32'd0;
            bbox_result_q <= 32'd0;
            bbox_valid_q  <= 1'b0;
            cnt_q         <= 16'd0;
`ifdef BBOX_SCAN_TIMEOUT_EN
            err_q         <= 1'b0;
            wdg_q         <= 8'd0;
`endif
        end else begin
            done_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            det_wr_en_q <= 1'b0;
            if (abort && state_q != IDLE) begin
                state_q      <= IDLE;
                busy_q       <= 1'b0;
                bbox_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (start) begin
                        state_q      <= CLEAR;
                        busy_q       <= 1'b1;
                        bbox_valid_q <= 1'b0;
                        det_data_q   <= {8'hFF, 24'd99999};
                        cnt_q        <= 16'd0;
`ifdef BBOX_SCAN_TIMEOUT_EN
                        err_q        <= 1'b0;
`endif
                    end
                    // The detector clear marker must not linger past CLEAR.
                    CLEAR: begin
                        state_q    <= FETCH;
                        det_data_q <= 32'd0;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= cnt_q;
                    end
                    FETCH: begin
                        state_q <= WAIT;
`ifdef BBOX_SCAN_TIMEOUT_EN
                        wdg_q   <= 8'd0;
`endif
                    end
                    WAIT: if (mem_rvalid) begin
                        state_q     <= PUSH;
                        det_wr_en_q <= 1'b1;
                        det_data_q  <= {mem_rdata, 8'h00, cnt_q};
                    end
`ifdef BBOX_SCAN_TIMEOUT_EN
                    else if (wdg_q == 8'(TIMEOUT - 1)) begin
                        state_q <= ERROR;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else wdg_q <= wdg_q + 8'd1;
`endif
                    PUSH: if (cnt_q == LAST) state_q <= DRAIN;
                    else begin
                        state_q    <= FETCH;
                        cnt_q      <= cnt_q + 16'd1;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= cnt_q + 16'd1;
                    end
                    DRAIN: begin
                        state_q       <= DONE;
                        bbox_result_q <= det_out;
                        done_q        <= 1'b1;
                        bbox_valid_q  <= 1'b1;
                        busy_q        <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_rd      = mem_rd_q;
    assign mem_addr    = mem_addr_q;
    assign det_wr_en   = det_wr_en_q;
    assign det_data    = det_data_q;
    assign bbox_result = bbox_result_q;
    assign bbox_valid  = bbox_valid_q;
`ifdef BBOX_SCAN_TIMEOUT_EN
    assign err = err_q;
`else
    // Without the watchdog no error can occur; TIMEOUT has no effect.
    assign err = (TIMEOUT < 0);
`endif
endmodule

// File: tb/tb_bbox_scan_ctrl.sv
// tb_bbox_scan_ctrl: randomized frames, random read latency and stray rvalid pulses, on a reduced 20x10 frame
// so each scan stays short; expected boxes come from a direct scan of the frame array.
module tb_bbox_scan_ctrl;
    localparam int W = 20, H = 10, N = W * H * 3, TO = 255;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        busy, done, err, mem_rd, det_wr_en, bbox_valid;
    logic [15:0] mem_addr;
    logic [31:0] det_data, det_out, bbox_result;
    logic [7:0]  xmin, xmax, ymin, ymax;
    logic [7:0]  frame [N];
    int          checks = 0, failures = 0;
    int          hold_addr = -1, exp_idx = 0, a, n;
    bit          saw_done;

    always #5 clk = ~clk;

    bbox_scan_ctrl #(.WIDTH(W), .HEIGHT(H), .TIMEOUT(TO)) dut (
        .CLOCK_50(clk), .reset_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .err(err), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .det_wr_en(det_wr_en),
        .det_data(det_data), .det_out(det_out), .bbox_result(bbox_result), .bbox_valid(bbox_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int px(input int idx); return (idx / 3) % W; endfunction
    function automatic int py(input int idx); return H - 1 - (idx / 3) / W; endfunction

    // Dark bytes (< 0x80) contribute their pixel; rows are counted bottom-up.
    function automatic logic [31:0] exp_bbox();
        int x0 = W - 1, x1 = 0, y0 = H - 1, y1 = 0;
        for (int i = 0; i < N; i++) if (frame[i] < 8'h80) begin
            if (px(i) < x0) x0 = px(i);
            if (px(i) > x1) x1 = px(i);
            if (py(i) < y0) y0 = py(i);
            if (py(i) > y1) y1 = py(i);
        end
        return {8'(x0), 8'(x1), 8'(y0), 8'(y1)};
    endfunction

    // Detector stand-in: cleared by the 99999 marker, updated on each write.
    assign det_out = {xmin, xmax, ymin, ymax};
    always @(posedge clk) begin
        if (det_data[23:0] == 24'd99999) begin
            xmin <= 8'(W - 1); xmax <= 8'd0; ymin <= 8'(H - 1); ymax <= 8'd0;
        end else if (det_wr_en && det_data[31:24] < 8'h80) begin
            if (px(int'(det_data[23:0])) < int'(xmin)) xmin <= 8'(px(int'(det_data[23:0])));
            if (px(int'(det_data[23:0])) > int'(xmax)) xmax <= 8'(px(int'(det_data[23:0])));
            if (py(int'(det_data[23:0])) < int'(ymin)) ymin <= 8'(py(int'(det_data[23:0])));
            if (py(int'(det_data[23:0])) > int'(ymax)) ymax <= 8'(py(int'(det_data[23:0])));
        end
    end

    // Memory: answers each read after 1..3 cycles, sometimes adds a stray dark pulse afterwards.
    initial forever begin
        @(negedge clk);
        mem_rvalid = 1'b0;
        if (mem_rd && int'(mem_addr) != hold_addr) begin
            a = int'(mem_addr);
            repeat ($urandom_range(1, 3)) @(negedge clk);
            mem_rdata  = frame[a];
            mem_rvalid = 1'b1;
            @(negedge clk);
            mem_rvalid = ($urandom_range(0, 3) == 0);
            mem_rdata  = 8'h00;
        end
    end

    // Every detector write must carry the next byte in address order.
    always @(negedge clk) if (det_wr_en) begin
        chk("push", det_data, {(exp_idx < N) ? frame[exp_idx] : 8'h00, 8'h00, 16'(exp_idx)});
        exp_idx++;
    end

    task automatic fill_white();
        for (int i = 0; i < N; i++) frame[i] = 8'hFF;
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) frame[i] = 8'($urandom_range(128, 255));
        repeat ($urandom_range(1, 4)) frame[$urandom_range(0, N - 1)] = 8'($urandom_range(0, 127));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " busy"}, busy, 0);         chk({tag, " done"}, done, 0);
        chk({tag, " err"}, err, 0);           chk({tag, " mem_rd"}, mem_rd, 0);
        chk({tag, " mem_addr"}, mem_addr, 0); chk({tag, " det_wr_en"}, det_wr_en, 0);
        chk({tag, " det_data"}, det_data, 0); chk({tag, " bbox_result"}, bbox_result, 0);
        chk({tag, " bbox_valid"}, bbox_valid, 0);
    endtask

    task automatic kick();
        @(negedge clk); start = 1'b1; exp_idx = 0;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic run_scan(input string tag, input logic [31:0] expv);
        int k = 0;
        kick();
        chk({tag, " busy"}, busy, 1);
        chk({tag, " clear"}, det_data, {8'hFF, 24'd99999});
        chk({tag, " valid cleared"}, bbox_valid, 0);
        while (!done && k < N * 8 + 50) begin @(negedge clk); k++; end
        chk({tag, " done"}, done, 1);
        chk({tag, " bbox"}, bbox_result, expv);
        chk({tag, " valid"}, bbox_valid, 1);
        chk({tag, " busy end"}, busy, 0);
        chk({tag, " err"}, err, 0);
        chk({tag, " pushes"}, exp_idx, N);
        @(negedge clk);
        chk({tag, " done pulse"}, done, 0);
        chk({tag, " bbox hold"}, bbox_result, expv);
    endtask

    task automatic wait_push(input int idx);
        int k = 0;
        while (!(det_wr_en && int'(det_data[15:0]) == idx) && k < N * 8) begin @(negedge clk); k++; end
        chk("reach push", det_data[15:0], 16'(idx));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;

        fill_white();                run_scan("white", 32'h13000900);
        frame[0] = 8'h10;            run_scan("dark first", 32'h00000909);
        fill_white(); frame[N-1] = 8'h10; run_scan("dark last", 32'h13130000);
        fill_white();                run_scan("white again", 32'h13000900);
        for (int r = 0; r < 3; r++) begin fill_random(); run_scan("random", exp_bbox()); end

        fill_white(); frame[50] = 8'h20;
        kick();
        wait_push(300);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort mem_rd", mem_rd, 0);
        chk("abort valid", bbox_valid, 0);
        saw_done = done;
        repeat (20) begin @(negedge clk); saw_done |= done; end
        chk("abort no done", saw_done, 0);
        fill_random(); run_scan("after abort", exp_bbox());

        kick();
        wait_push(200);
        #2 rst_n = 1'b0;
        #1 chk_reset("async reset");
        @(negedge clk); rst_n = 1'b1;
        fill_random(); run_scan("after reset", exp_bbox());

        fill_white(); hold_addr = 100;
        kick();
        n = 0;
        while (!(mem_rd && mem_addr == 16'd100) && n < N * 8) begin @(negedge clk); n++; end
        chk("reach addr 100", mem_addr, 16'd100);
`ifdef BBOX_SCAN_TIMEOUT_EN
        n = 0; saw_done = 1'b0;
        while (!err && n < 400) begin @(negedge clk); n++; saw_done |= done; end
        chk("timeout cycles", n, TO + 1);
        chk("timeout err", err, 1);
        chk("timeout busy", busy, 0);
        chk("timeout no done", saw_done, 0);
        @(negedge clk);
        chk("err hold", err, 1);
`else
        saw_done = 1'b0;
        repeat (400) begin @(negedge clk); saw_done |= done; end
        chk("wait busy", busy, 1);
        chk("wait err", err, 0);
        chk("wait no done", saw_done, 0);
        chk("wait no reread", mem_rd, 0);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("wait abort busy", busy, 0);
`endif
        hold_addr = -1;
        fill_random(); run_scan("after stall", exp_bbox());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
